// File: rtl/frame_acq_pkg.sv
// Shared constants for the frame acquisition sequencer: CSR map, bit indices,
// FSM states and register reset values.
package frame_acq_pkg;

   localparam logic [2:0] ADDR_CTRL       = 3'd0;
   localparam logic [2:0] ADDR_STATUS     = 3'd1;
   localparam logic [2:0] ADDR_PERIOD     = 3'd2;
   localparam logic [2:0] ADDR_NFRAMES    = 3'd3;
   localparam logic [2:0] ADDR_TIMEOUT    = 3'd4;
   localparam logic [2:0] ADDR_FRAME_NUM  = 3'd5;
   localparam logic [2:0] ADDR_TRIG_COUNT = 3'd6;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_TIMEOUT  = 2;
   localparam int ST_OVERRUN  = 3;
   localparam int ST_SPURIOUS = 4;

   localparam logic [31:0] DEF_PERIOD  = 32'd1000;
   localparam logic [31:0] DEF_NFRAMES = 32'd1;
   localparam logic [31:0] DEF_TIMEOUT = 32'd0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RSTS = 3'd1,
      TRIG = 3'd2,
      WAIT = 3'd3,
      GAP  = 3'd4,
      FIN  = 3'd5
   } state_t;

endpackage

// File: rtl/frame_acq_csr.sv
// Avalon-MM register file: control strobes, sticky W1C status, timing registers
// and a registered read mux (one cycle read latency).
module frame_acq_csr
   import frame_acq_pkg::*;
#(
   parameter int CNT_W = 27,
   parameter int TMR_W = 32
) (
   input  logic             clk_clk,
   input  logic             rst_reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_write,
   input  logic             avs_read,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   input  logic             busy,
   input  logic             set_done,
   input  logic             set_timeout,
   input  logic             set_overrun,
   input  logic             set_spurious,
   input  logic [CNT_W-1:0] frame_num,
   input  logic [31:0]      trig_count,
   output logic             start,
   output logic             stop,
   output logic             cont,
   output logic             irq,
   output logic [TMR_W-1:0] period,
   output logic [TMR_W-1:0] nframes,
   output logic [TMR_W-1:0] timeout
);

   logic        wr_ctrl;
   logic        wr_status;
   logic        irq_en;
   logic [4:1]  sticky;
   logic [4:1]  set_vec;
   logic [4:1]  w1c_vec;
   logic [31:0] rd_mux;

   assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
   assign wr_status = avs_write && (avs_address == ADDR_STATUS);
   // STOP dominates START when both arrive in one write
   assign start     = wr_ctrl && avs_writedata[CTRL_START] && !avs_writedata[CTRL_STOP];
   assign stop      = wr_ctrl && avs_writedata[CTRL_STOP];
   assign set_vec   = {set_spurious, set_overrun, set_timeout, set_done};
   assign w1c_vec   = wr_status ? avs_writedata[ST_SPURIOUS:ST_DONE] : 4'b0000;
   assign irq       = irq_en && (sticky[ST_DONE] || sticky[ST_TIMEOUT]);

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_CONT]   = cont;
            rd_mux[CTRL_IRQ_EN] = irq_en;
         end
         ADDR_STATUS: begin
            rd_mux[ST_BUSY]              = busy;
            rd_mux[ST_SPURIOUS:ST_DONE]  = sticky;
         end
         ADDR_PERIOD:     rd_mux = 32'(period);
         ADDR_NFRAMES:    rd_mux = 32'(nframes);
         ADDR_TIMEOUT:    rd_mux = 32'(timeout);
         ADDR_FRAME_NUM:  rd_mux = 32'(frame_num);
         ADDR_TRIG_COUNT: rd_mux = trig_count;
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         cont         <= 1'b0;
         irq_en       <= 1'b0;
         sticky       <= '0;
         period       <= TMR_W'(DEF_PERIOD);
         nframes      <= TMR_W'(DEF_NFRAMES);
         timeout      <= TMR_W'(DEF_TIMEOUT);
         avs_readdata <= '0;
      end else begin
         if (wr_ctrl) begin
            cont   <= avs_writedata[CTRL_CONT];
            irq_en <= avs_writedata[CTRL_IRQ_EN];
         end
         if (avs_write && (avs_address == ADDR_PERIOD))  period  <= TMR_W'(avs_writedata);
         if (avs_write && (avs_address == ADDR_NFRAMES)) nframes <= TMR_W'(avs_writedata);
         if (avs_write && (avs_address == ADDR_TIMEOUT)) timeout <= TMR_W'(avs_writedata);
         // a set event in the same cycle as a W1C keeps the bit
         sticky <= set_vec | (sticky & ~w1c_vec);
         if (avs_read) avs_readdata <= rd_mux;
      end
   end

endmodule

// File: rtl/frame_acq_sequencer.sv
// Frame acquisition sequencer: sensor reset pulse, periodic triggers, frame
// counting on frame_done rising edges, frame-count/period/timeout enforcement.
module frame_acq_sequencer
   import frame_acq_pkg::*;
#(
   parameter int CNT_W    = 27,
   parameter int TMR_W    = 32,
   parameter int RST_HOLD = 4
) (
   input  logic             clk_clk,
   input  logic             rst_reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_write,
   input  logic             avs_read,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   input  logic             frame_done,
   output logic             trig_out,
   output logic             sensor_rst,
   output logic             busy,
   output logic             irq,
   output logic [CNT_W-1:0] frame_num
);

   localparam int HW = $clog2(RST_HOLD + 1);

   state_t           state, state_d;
   logic             start, stop, cont;
   logic [TMR_W-1:0] period, nframes, timeout;
   logic [TMR_W-1:0] per_eff, per_cnt, to_cnt, nframes_q;
   logic             to_en;
   logic [HW-1:0]    hold_cnt;
   logic [31:0]      trig_count;
   logic             done_q, fd_edge;
   logic             hold_last, per_exp, to_hit, last_frame;
   logic             set_done, set_timeout, set_overrun, set_spurious;
   logic             frame_inc, run_clr;

   assign fd_edge    = frame_done && !done_q;
   assign hold_last  = (hold_cnt == HW'(RST_HOLD - 1));
   assign per_eff    = (period < TMR_W'(2)) ? TMR_W'(2) : period;
   assign per_exp    = (per_cnt <= TMR_W'(1));
   assign to_hit     = to_en && (to_cnt == '0);
   assign last_frame = !cont && ((TMR_W'(frame_num) + TMR_W'(1)) == nframes_q);

   assign trig_out   = (state == TRIG);
   assign sensor_rst = (state == RSTS);
   assign busy       = (state != IDLE);

   always_comb begin
      state_d      = state;
      set_done     = 1'b0;
      set_timeout  = 1'b0;
      set_overrun  = 1'b0;
      set_spurious = 1'b0;
      frame_inc    = 1'b0;
      run_clr      = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_d = RSTS;
            run_clr = 1'b1;
         end
         RSTS: if (hold_last) state_d = ((nframes == '0) && !cont) ? FIN : TRIG;
         TRIG: state_d = WAIT;
         WAIT: begin
            // an edge on the timeout cycle is counted and suppresses the timeout
            if (fd_edge) begin
               frame_inc = 1'b1;
               if (last_frame) state_d = FIN;
               else if (per_exp) begin
                  set_overrun = 1'b1;
                  state_d     = TRIG;
               end else state_d = GAP;
            end else if (to_hit) begin
               set_timeout = 1'b1;
               state_d     = IDLE;
            end
         end
         GAP: if (per_exp) state_d = TRIG;
         FIN: begin
            set_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (fd_edge && (state != IDLE) && (state != WAIT)) set_spurious = 1'b1;
      if (stop && (state != IDLE)) begin
         state_d     = IDLE;
         frame_inc   = 1'b0;
         set_done    = 1'b0;
         set_timeout = 1'b0;
         set_overrun = 1'b0;
      end
   end

   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         state      <= IDLE;
         done_q     <= 1'b0;
         hold_cnt   <= '0;
         frame_num  <= '0;
         trig_count <= '0;
         per_cnt    <= '0;
         to_cnt     <= '0;
         to_en      <= 1'b0;
         nframes_q  <= TMR_W'(DEF_NFRAMES);
      end else begin
         state    <= state_d;
         done_q   <= frame_done;
         hold_cnt <= (state == RSTS) ? hold_cnt + HW'(1) : '0;
         if (run_clr) begin
            frame_num  <= '0;
            trig_count <= '0;
         end else begin
            if (frame_inc) frame_num <= frame_num + CNT_W'(1);
            if (state == TRIG) trig_count <= trig_count + 32'd1;
         end
         // timing registers are sampled only at a trigger so mid-run writes wait for the next one
         if (state == TRIG) begin
            per_cnt   <= per_eff - TMR_W'(1);
            to_cnt    <= timeout - TMR_W'(1);
            to_en     <= (timeout != '0);
            nframes_q <= nframes;
         end else if ((state == WAIT) || (state == GAP)) begin
            if (per_cnt != '0) per_cnt <= per_cnt - TMR_W'(1);
            if (to_cnt != '0)  to_cnt  <= to_cnt - TMR_W'(1);
         end
      end
   end

   frame_acq_csr #(.CNT_W(CNT_W), .TMR_W(TMR_W)) u_csr (
      .clk_clk      (clk_clk),
      .rst_reset    (rst_reset),
      .avs_address  (avs_address),
      .avs_write    (avs_write),
      .avs_read     (avs_read),
      .avs_writedata(avs_writedata),
      .avs_readdata (avs_readdata),
      .busy         (busy),
      .set_done     (set_done),
      .set_timeout  (set_timeout),
      .set_overrun  (set_overrun),
      .set_spurious (set_spurious),
      .frame_num    (frame_num),
      .trig_count   (trig_count),
      .start        (start),
      .stop         (stop),
      .cont         (cont),
      .irq          (irq),
      .period       (period),
      .nframes      (nframes),
      .timeout      (timeout)
   );

endmodule

// File: tb/tb_frame_acq_sequencer.sv
// Directed bench for frame_acq_sequencer; CSR read results go through an expected-value queue.
module tb_frame_acq_sequencer;

   logic        clk_clk = 1'b0;
   logic        rst_reset;
   logic [2:0]  avs_address;
   logic        avs_write;
   logic        avs_read;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        frame_done;
   logic        trig_out;
   logic        sensor_rst;
   logic        busy;
   logic        irq;
   logic [26:0] frame_num;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   frame_acq_sequencer dut (
      .clk_clk      (clk_clk),
      .rst_reset    (rst_reset),
      .avs_address  (avs_address),
      .avs_write    (avs_write),
      .avs_read     (avs_read),
      .avs_writedata(avs_writedata),
      .avs_readdata (avs_readdata),
      .frame_done   (frame_done),
      .trig_out     (trig_out),
      .sensor_rst   (sensor_rst),
      .busy         (busy),
      .irq          (irq),
      .frame_num    (frame_num)
   );

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      step(1);
      avs_write     = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      avs_address = a;
      avs_read    = 1'b1;
      step(1);
      avs_read    = 1'b0;
      check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
   endtask

   task automatic wait_trig(input string tag, input int budget, output int t);
      logic seen;
      seen = 1'b0;
      t    = -1;
      for (int i = 0; i < budget; i++) begin
         if (trig_out) begin
            seen = 1'b1;
            t    = cyc;
            break;
         end
         step(1);
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic pulse_done_after(input int n);
      step(n);
      frame_done = 1'b1;
      step(1);
      frame_done = 1'b0;
   endtask

   initial begin
      int s, t, tp, ntrig;
      rst_reset     = 1'b1;
      avs_address   = '0;
      avs_write     = 1'b0;
      avs_read      = 1'b0;
      avs_writedata = '0;
      frame_done    = 1'b0;
      step(3);
      check("rst_trig", {31'd0, trig_out}, 32'd0);
      check("rst_sensor_rst", {31'd0, sensor_rst}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_frame_num", 32'(frame_num), 32'd0);
      check("rst_readdata", avs_readdata, 32'd0);
      rst_reset = 1'b0;
      step(1);
      csr_read(3'd2, 32'd1000, "rst_period");
      csr_read(3'd3, 32'd1, "rst_nframes");
      csr_read(3'd4, 32'd0, "rst_timeout");
      csr_read(3'd1, 32'd0, "rst_status");
      csr_read(3'd0, 32'd0, "rst_ctrl");
      csr_read(3'd7, 32'd0, "addr7_zero");

      // three frames, each completing 4 cycles after its trigger
      csr_write(3'd2, 32'd10);
      csr_write(3'd3, 32'd3);
      s = cyc;
      csr_write(3'd0, 32'h9);
      check("t1_sensor_rst_first", {31'd0, sensor_rst}, 32'd1);
      step(3);
      check("t1_sensor_rst_last", {31'd0, sensor_rst}, 32'd1);
      step(1);
      check("t1_sensor_rst_drop", {31'd0, sensor_rst}, 32'd0);
      wait_trig("t1_trig0_seen", 5, t);
      check("t1_start_to_trig", 32'(t - s), 32'd5);
      tp = t;
      pulse_done_after(4);
      for (int k = 1; k < 3; k++) begin
         wait_trig("t1_trig_seen", 20, t);
         check("t1_trig_spacing", 32'(t - tp), 32'd10);
         tp = t;
         pulse_done_after(4);
      end
      check("t1_busy_in_fin", {31'd0, busy}, 32'd1);
      step(1);
      check("t1_busy_after_fin", {31'd0, busy}, 32'd0);
      check("t1_irq", {31'd0, irq}, 32'd1);
      check("t1_frame_num", 32'(frame_num), 32'd3);
      csr_read(3'd1, 32'h2, "t1_status_done");
      csr_read(3'd6, 32'd3, "t1_trig_count");
      csr_write(3'd1, 32'h1E);
      check("t1_irq_cleared", {31'd0, irq}, 32'd0);

      // timeout with no frame_done
      csr_write(3'd4, 32'd20);
      csr_write(3'd0, 32'h9);
      wait_trig("t2_trig_seen", 10, t);
      step(20);
      check("t2_busy_at_limit", {31'd0, busy}, 32'd1);
      step(1);
      check("t2_busy_after", {31'd0, busy}, 32'd0);
      check("t2_irq", {31'd0, irq}, 32'd1);
      check("t2_frame_num", 32'(frame_num), 32'd0);
      csr_read(3'd1, 32'h4, "t2_status_timeout");
      csr_write(3'd1, 32'h1E);
      csr_write(3'd4, 32'd0);

      // overrun: frame completes 15 cycles after a 10-cycle period trigger
      csr_write(3'd3, 32'd2);
      csr_write(3'd0, 32'h1);
      wait_trig("t3_trig0_seen", 10, tp);
      pulse_done_after(15);
      wait_trig("t3_trig1_seen", 5, t);
      check("t3_overrun_retrig", 32'(t - tp), 32'd16);
      pulse_done_after(4);
      step(1);
      check("t3_busy_done", {31'd0, busy}, 32'd0);
      check("t3_irq_masked", {31'd0, irq}, 32'd0);
      csr_read(3'd1, 32'hA, "t3_status_overrun");
      csr_write(3'd1, 32'h1E);

      // continuous mode stopped after five frames
      csr_write(3'd0, 32'h5);
      for (int k = 0; k < 5; k++) begin
         wait_trig("t4_trig_seen", 20, t);
         pulse_done_after(4);
      end
      csr_write(3'd0, 32'h6);
      ntrig = 0;
      for (int i = 0; i < 30; i++) begin
         if (trig_out) ntrig++;
         step(1);
      end
      check("t4_no_trig_after_stop", 32'(ntrig), 32'd0);
      check("t4_frame_num", 32'(frame_num), 32'd5);
      csr_read(3'd1, 32'h0, "t4_status_no_done");
      csr_read(3'd0, 32'h4, "t4_ctrl_readback");

      // edge during GAP is spurious and not counted
      csr_write(3'd0, 32'h1);
      wait_trig("t5_trig_seen", 10, t);
      pulse_done_after(4);
      pulse_done_after(1);
      check("t5_frame_num", 32'(frame_num), 32'd1);
      csr_read(3'd1, 32'h11, "t5_status_spurious");
      csr_write(3'd0, 32'h2);
      csr_write(3'd1, 32'h10);
      csr_read(3'd1, 32'h0, "t5_status_w1c");

      // zero frames: reset pulse only, then done
      csr_write(3'd3, 32'd0);
      s = cyc;
      csr_write(3'd0, 32'h1);
      ntrig = 0;
      for (int i = 1; i <= 4; i++) begin
         check("t6_sensor_rst_held", {31'd0, sensor_rst}, 32'd1);
         if (trig_out) ntrig++;
         step(1);
      end
      check("t6_sensor_rst_drop", {31'd0, sensor_rst}, 32'd0);
      if (trig_out) ntrig++;
      step(1);
      check("t6_no_trig", 32'(ntrig), 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_hold_span", 32'(cyc - s), 32'd6);
      csr_read(3'd1, 32'h2, "t6_status_done");
      csr_write(3'd1, 32'h1E);

      // asynchronous reset in the middle of a trigger cycle
      csr_write(3'd3, 32'd3);
      csr_write(3'd0, 32'h9);
      wait_trig("t7_trig_seen", 10, t);
      #1 rst_reset = 1'b1;
      #1;
      check("t7_trig_reset", {31'd0, trig_out}, 32'd0);
      check("t7_busy_reset", {31'd0, busy}, 32'd0);
      check("t7_sensor_rst_reset", {31'd0, sensor_rst}, 32'd0);
      check("t7_irq_reset", {31'd0, irq}, 32'd0);
      step(1);
      rst_reset = 1'b0;
      step(1);
      csr_read(3'd2, 32'd1000, "t7_period_default");
      csr_read(3'd3, 32'd1, "t7_nframes_default");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_acq_sequencer.md
# frame_acq_sequencer

Acquisition controller for the sensor frame path. It issues periodic frame triggers to the sensor interface and counts completed frames by rising edges of the sensor status bit. It enforces a programmed frame count, period and timeout, and pulses the sensor-interface/frame-counter reset at run start. Host control is through a small Avalon-MM CSR slave in the Qsys system.

## Interface
- CNT_W, 27: frame number width
- TMR_W, 32: period/timeout/N-frames register width
- RST_HOLD, 4: cycles sensor_rst is held at run start
- clk_clk  in  1  system clock
- rst_reset  in  1  reset, asynchronous, active-high
- avs_address  in  3  CSR word address
- avs_write / avs_read  in  1  CSR strobes
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, 1-cycle latency
- frame_done  in  1  sensor status_out[0]; synchronous to clk_clk
- trig_out  out  1  one-cycle frame trigger pulse
- sensor_rst  out  1  reset to sensor interface int_rst / frame counter
- busy  out  1  run active
- irq  out  1  level interrupt
- frame_num  out  CNT_W  frames completed in the current run

## Operation
- CSR 0 CTRL (write): bit0 START, self-clearing; bit1 STOP; bit2 CONT, the continuous mode; bit3 IRQ_EN. Bits 2–3 read back.
- CSR 1 STATUS: bit0 busy (RO). Sticky W1C bits: bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN, bit4 SPURIOUS.
- CSR 2 PERIOD: cycles between triggers. Values below 2 behave as 2.
- CSR 3 NFRAMES.
- CSR 4 TIMEOUT: cycles from trigger; 0 disables the timeout.
- CSR 5 FRAME_NUM (RO), CSR 6 TRIG_COUNT (RO). Addresses 7+ read 0.
- Edge detect: frame_done is registered into done_q. edge = frame_done & ~done_q.
- FSM states:
  - IDLE: START → RSTS; clears frame_num and TRIG_COUNT.
  - RSTS: sensor_rst=1 for RST_HOLD cycles. Then, if NFRAMES=0 and ~CONT → FIN; else → TRIG.
  - TRIG: trig_out=1 for one cycle; loads the period and timeout counters; TRIG_COUNT++ → WAIT.
  - WAIT: on edge, frame_num++.
    - If ~CONT and frame_num+1 = NFRAMES → FIN.
    - Else if the period counter has expired → OVERRUN set, → TRIG.
    - Else → GAP.
    - If the timeout expires with no edge → TIMEOUT set, → IDLE. DONE is not set.
  - GAP: on period counter expiry → TRIG.
  - FIN: DONE set, → IDLE.
- STOP in any non-IDLE state: → IDLE next cycle. No further trig_out; DONE is not set; frame_num holds.
- START while busy: ignored. START and STOP in the same write: STOP wins.
- An edge outside WAIT while busy sets SPURIOUS and is not counted. Edges in IDLE are ignored.
- frame_num wraps from 2^CNT_W−1 to 0. TRIG_COUNT wraps at 2^32.
- irq = IRQ_EN & (DONE | TIMEOUT).
- busy = state ≠ IDLE.
- CSR writes to PERIOD/NFRAMES/TIMEOUT during a run take effect at the next TRIG.

## Timing
- Reset values:
  - state IDLE; trig_out, sensor_rst, busy, irq = 0.
  - frame_num = 0; avs_readdata = 0.
  - PERIOD = 1000, NFRAMES = 1, TIMEOUT = 0; all STATUS and CTRL bits 0.
- START write at cycle t: sensor_rst high t+1..t+RST_HOLD; trig_out at t+RST_HOLD+1.
- frame_done rising at cycle e (in WAIT): frame_num updates at e+1 and the state leaves WAIT at e+1.
- Consecutive triggers are exactly max(PERIOD,2) cycles apart when frames complete in time. On overrun, the next trigger comes 1 cycle after the WAIT exit.
- Timeout fires when the cycle count since trig_out equals TIMEOUT with no edge yet. An edge on that same cycle wins: it is counted and no timeout is raised.
- W1C write and a set event in the same cycle: the set wins.
- rst_reset mid-run: all outputs go to reset values immediately; trig_out does not glitch high.

## Structure
- Package frame_acq_pkg:
  - CSR address constants
  - CTRL/STATUS bit indices
  - FSM state enum (IDLE, RSTS, TRIG, WAIT, GAP, FIN)
  - default register values
- Sub-module frame_acq_csr: Avalon register file, W1C/sticky logic, readdata mux.
- The top level holds the FSM, counters and edge detect.

## Test plan
- PERIOD=10, NFRAMES=3, frame_done pulsed 4 cycles after each trigger → 3 triggers 10 cycles apart; frame_num=3; DONE=1; irq=1 with IRQ_EN; busy falls after FIN.
- TIMEOUT=20, no frame_done → TIMEOUT=1 at trigger+20; state IDLE; frame_num=0; DONE=0.
- PERIOD=10, frame_done arriving 15 cycles after the trigger → OVERRUN=1; next trig_out 1 cycle after the WAIT exit.
- CONT=1, then STOP after 5 frames → no trig_out after STOP+1; frame_num=5; DONE=0.
- frame_done edge during GAP → SPURIOUS=1; frame_num unchanged. W1C write of 0x10 → SPURIOUS=0.
- NFRAMES=0, CONT=0, START → sensor_rst held 4 cycles; no trig_out; DONE=1. rst_reset asserted mid-run → all outputs 0 the same cycle.
